rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- Grants are produced both as a one-hot vector and as a 2-bit encoded index, so downstream muxes can select with either form.
- Grants are registered and held until the owner releases, which makes this the sequencing and ownership controller in front of a shared datapath.

Parameters:
- MAX_HOLD, 15: maximum cycles a grant may be held before a forced release; used only with ARB_TIMEOUT_EN.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; req[i] high means requester i wants the resource
- done  input  1  owner-release strobe; sampled only in GRANT
- gnt  output  4  registered one-hot grant; 4'b0000 when no grant
- gnt_idx  output  2  registered encoded index of the granted requester (0..3)
- gnt_valid  output  1  high while any grant is held; equals |gnt
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst_n low):
  - Takes effect immediately, asynchronously.
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0.
  - state=IDLE, priority pointer ptr=2'b11, hold counter=0.
  - Deassertion is synchronous to clk by the system; the block only samples on clk edges.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE with all outputs low.
  - Otherwise select the first set bit of req, scanning (ptr+1), (ptr+2), (ptr+3), (ptr+4) mod 4.
  - At the next edge: gnt[sel]=1, gnt_idx=sel, gnt_valid=1, state->GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
- GRANT:
  - Outputs hold stable.
  - Release condition: done==1, or req[gnt_idx]==0 (requester withdrew).
  - On release, at the next edge: gnt=0, gnt_valid=0, ptr<=gnt_idx, state->IDLE.
  - gnt_idx keeps its last value while gnt_valid=0.
- Mandatory gap: one IDLE cycle separates any two grants. There are no back-to-back grants, even when other requests are pending.
- Fairness:
  - The just-served requester has lowest priority in the next arbitration.
  - With all four requesting continuously, the grant order is 0,1,2,3,0,...
- Requests arriving during GRANT are ignored until IDLE. They are not latched; a requester must hold req until granted.
- Simultaneous events:
  - done together with changes on other req bits: release first; the new arbitration happens in the IDLE cycle that follows.
  - done while req[gnt_idx] is still high: still releases.
- done in IDLE is ignored.
- Reset mid-grant: outputs clear immediately, and ptr returns to 3, so requester 0 has priority after reset.
- Invariants, true at all times:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt_idx equals the encoding of gnt.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - The hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When it reaches MAX_HOLD with no normal release, the block performs a forced release at that edge: same effects as a normal release, plus timeout=1 for exactly one cycle.
  - A normal release in the same cycle takes precedence; timeout stays 0.
  - The counter saturates and never wraps.
- Not defined:
  - No counter logic is built; timeout is tied to 0.
  - A grant may be held indefinitely.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0 throughout.
- Single requester: req=4'b0100 at cycle 0 -> at cycle 1 gnt=4'b0100, gnt_idx=2; done pulse at cycle 4 -> gnt=0 at cycle 5.
- Fairness: req=4'b1111 held, done pulsed every cycle while in GRANT -> grant order idx 0,1,2,3,0 with one idle cycle between each.
- Withdrawal and re-arbitration:
  - Grant to requester 1, then drop req[1] with req=4'b1001 -> gnt clears next cycle.
  - Following grant goes to idx 3, not idx 0.
- Async reset: assert rst_n=0 mid-cycle while gnt=4'b0010 -> gnt=0 before the next clk edge; after release, req=4'b1111 grants idx 0.
- ARB_TIMEOUT_EN with MAX_HOLD=3: req=4'b0001 held, done=0 -> gnt asserted, forced release after 3 GRANT cycles, timeout high for exactly 1 cycle; without the macro, gnt is held for 20+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot and encoded grants.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("rr_arbiter_4: CNT_W too narrow for MAX_HOLD");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       to_q, to_d;

  logic       found;
  logic [1:0] sel;
  logic [1:0] cand;
  logic       rel_normal;
  logic       rel_force;

  // Scan starts just past the last-served requester, so it gets lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign rel_normal = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count reaching MAX_HOLD at this edge means this is the last allowed cycle.
  assign rel_force = (cnt_q >= CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign rel_force = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << sel;
          idx_d   = sel;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel_normal || rel_force) begin
          gnt_d   = 4'b0000;
          ptr_d   = idx_q;
          state_d = IDLE;
          to_d    = rel_force & ~rel_normal;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'b00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = to_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; covers the ARB_TIMEOUT_EN build when that macro is defined.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_4 #(.MAX_HOLD(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] i);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(i));
    check({tag, ".vld"}, 32'(gnt_valid), 32'(|g));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    check_grant("reset", 4'b0000, 2'd0);
    check("reset.to", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      tick();
      check_grant("idle", 4'b0000, 2'd0);
    end

    // Single requester: grant after one cycle, held until done.
    req = 4'b0100;
    tick();
    check_grant("single", 4'b0100, 2'd2);
    tick();
    tick();
    check_grant("single.hold", 4'b0100, 2'd2);
    done = 1'b1;
    tick();
    check_grant("single.rel", 4'b0000, 2'd2);
    check("single.to", 32'(timeout), 32'd0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check_grant("single.idle", 4'b0000, 2'd2);

    // Fairness with all requesting and done high: one idle cycle between grants.
    do_reset();
    req  = 4'b1111;
    done = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check_grant($sformatf("fair%0d", n), 4'b0001 << order[n], 2'(order[n]));
      tick();
      check_grant($sformatf("fair%0d.gap", n), 4'b0000, 2'(order[n]));
    end
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Withdrawal: ptr=0, grant to 1, withdraw; next grant goes to 3, not 0.
    req = 4'b0010;
    tick();
    check_grant("wd.g1", 4'b0010, 2'd1);
    req = 4'b1001;
    tick();
    check_grant("wd.rel", 4'b0000, 2'd1);
    tick();
    check_grant("wd.g3", 4'b1000, 2'd3);
    done = 1'b1;
    tick();
    check_grant("wd.rel3", 4'b0000, 2'd3);
    done = 1'b0;

    // Async reset mid-grant clears outputs before the next edge.
    req = 4'b0010;
    tick();
    check_grant("ar.g1", 4'b0010, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_grant("ar.async", 4'b0000, 2'd0);
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    check_grant("ar.after", 4'b0001, 2'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check_grant("ar.idle", 4'b0000, 2'd0);

    req = 4'b0001;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      check_grant($sformatf("to.hold%0d", c), 4'b0001, 2'd0);
      check($sformatf("to.low%0d", c), 32'(timeout), 32'd0);
    end
    tick();
    check_grant("to.force", 4'b0000, 2'd0);
    check("to.pulse", 32'(timeout), 32'd1);
    tick();
    check_grant("to.regrant", 4'b0001, 2'd0);
    check("to.once", 32'(timeout), 32'd0);
`else
    for (int c = 0; c < 22; c++) begin
      tick();
      check_grant($sformatf("hold%0d", c), 4'b0001, 2'd0);
      check($sformatf("hold%0d.to", c), 32'(timeout), 32'd0);
    end
`endif
    req = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
